// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM:
// state codes, opcode constants and the datapath select encodings.
package mc_ctrl_pkg;

    localparam int OP_W = 6;

    // Controller states; FETCH must stay at code 0 so a cleared register is a fetch.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXEC     = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_B      = 2'd0,
        SRCB_FOUR   = 2'd1,
        SRCB_IMM    = 2'd2,
        SRCB_IMM_SH = 2'd3
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JUMP   = 2'd2
    } pc_src_e;

    // Everything the datapath needs from one state, before any memory-wait gating.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        pc_src_e    pc_src;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure state -> control-word decoder for the multi-cycle MIPS controller.
// Unlisted state codes decode to all-zero so no enable fires in them.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    // Moore decode: start from all enables/selects at zero, then set per state.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
            end
            DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.alu_op    = ALU_ADD;
            end
            MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            MEMRD: begin
                ctrl_o.iord = 1'b1;
            end
            MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            ALUWB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_src        = PCSRC_ALUOUT;
                ctrl_o.pc_write_cond = 1'b1;
            end
            ADDIEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            JUMP: begin
                ctrl_o.pc_src   = PCSRC_JUMP;
                ctrl_o.pc_write = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic,
// illegal-opcode flag and the PC enable combine.
// Optional build macro MC_CTRL_MEMWAIT_EN adds a mem_ready input that holds
// FETCH, MEMRD and MEMWR until memory completes; without it memory is single-cycle.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = OP_W
) (
    input  logic           clk,
    input  logic           rst,
`ifdef MC_CTRL_MEMWAIT_EN
    input  logic           mem_ready,
`endif
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           pc_en,
    output logic           ir_write,
    output logic           mem_write,
    output logic           reg_write,
    output logic           iord,
    output logic           mem_to_reg,
    output logic           reg_dst,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic [1:0]     pc_src,
    output logic           illegal_op,
    output logic [3:0]     state_o
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    logic   memReady;
    logic   memGate;

`ifdef MC_CTRL_MEMWAIT_EN
    assign memReady = mem_ready;
`else
    assign memReady = 1'b1;
`endif

    mc_ctrl_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    // Memory-access states only complete (and only fire their strobes) once memory is ready.
    assign memGate = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) ? memReady : 1'b1;

    // State register; reset abandons any instruction in flight and restarts at fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and the illegal-opcode pulse raised while decoding.
    always_comb begin
        state_d    = state_q;
        illegal_op = 1'b0;
        case (state_q)
            FETCH:  state_d = memReady ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW) begin
                    state_d = MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD:    state_d = memReady ? MEMWB : MEMRD;
            MEMWB:    state_d = FETCH;
            MEMWR:    state_d = memReady ? FETCH : MEMWR;
            EXEC:     state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            ADDIEXEC: state_d = ADDIWB;
            ADDIWB:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    assign pc_en      = (ctrl.pc_write & memGate) | (ctrl.pc_write_cond & zero);
    assign ir_write   = ctrl.ir_write & memGate;
    assign mem_write  = ctrl.mem_write & memGate;
    assign reg_write  = ctrl.reg_write;
    assign iord       = ctrl.iord;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_dst    = ctrl.reg_dst;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;
    assign state_o    = state_q;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle MIPS main control state machine.
- Sits directly upstream of the datapath's 32-bit enable-gated state registers (PC, IR, MDR, A/B, ALUOut).
- Drives their write enables and the datapath mux selects from a registered state, one instruction step per clock.
- Consumes IR opcode and ALU zero flag from the datapath.

Parameters:
OPW, 6, opcode field width (fixed by ISA; parameterised only for package constant sizing)

Ports:
clk  input  1  system clock; state register updates on rising edge
rst  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26] from instruction register output
zero  input  1  ALU zero flag, valid in BRANCH state
pc_en  output  1  PC register enable = pc_write | (pc_write_cond & zero)
ir_write  output  1  IR register enable
mem_write  output  1  data memory write strobe
reg_write  output  1  register file write enable
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = MDR
reg_dst  output  1  dest select: 0 = rt, 1 = rd
alu_src_a  output  1  0 = PC, 1 = A
alu_src_b  output  2  0 = B, 1 = const 4, 2 = signext imm, 3 = signext imm<<2
alu_op  output  2  0 = add, 1 = sub, 2 = funct-decoded
pc_src  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target
illegal_op  output  1  one-cycle pulse in DECODE on unsupported opcode
state_o  output  4  current state code, debug/visibility

Behaviour:
- Decided: one clock `clk`; reset `rst` is synchronous and active-high.
- State register on posedge clk. All outputs except pc_en are pure Moore decodes of state. They are therefore stable well before the negedge capture of the downstream registers.
- pc_en is combinational from state and zero.
- Reset (rst = 1 at posedge): state <= FETCH. While in reset, and in the first cycle after it, outputs are the FETCH decode. Reset mid-instruction abandons it; no partial register or memory write occurs after the reset edge.
- Decode defaults: all enables 0, all selects 0.
- States and per-state outputs/transitions:
  - FETCH: iord = 0, ir_write = 1, alu_src_a = 0, alu_src_b = 1, alu_op = 0, pc_src = 0, pc_write = 1. Next: DECODE.
  - DECODE: alu_src_a = 0, alu_src_b = 3, alu_op = 0. Next by opcode: lw 0x23 / sw 0x2B -> MEMADR; R-type 0x00 -> EXEC; beq 0x04 -> BRANCH; addi 0x08 -> ADDIEXEC; j 0x02 -> JUMP. Any other opcode -> FETCH with illegal_op = 1 (treated as NOP).
  - MEMADR: alu_src_a = 1, alu_src_b = 2, alu_op = 0. Next: lw -> MEMRD, sw -> MEMWR.
  - MEMRD: iord = 1. Next: MEMWB.
  - MEMWB: reg_dst = 0, mem_to_reg = 1, reg_write = 1. Next: FETCH.
  - MEMWR: iord = 1, mem_write = 1. Next: FETCH.
  - EXEC: alu_src_a = 1, alu_src_b = 0, alu_op = 2. Next: ALUWB.
  - ALUWB: reg_dst = 1, mem_to_reg = 0, reg_write = 1. Next: FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = 1, pc_src = 1, pc_write_cond = 1. Next: FETCH.
  - ADDIEXEC: alu_src_a = 1, alu_src_b = 2, alu_op = 0. Next: ADDIWB.
  - ADDIWB: reg_dst = 0, mem_to_reg = 0, reg_write = 1. Next: FETCH.
  - JUMP: pc_src = 2, pc_write = 1. Next: FETCH.
- Opcode is sampled only in DECODE and MEMADR. IR holds it stable because ir_write = 1 only in FETCH.
- Latency in cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Unreachable state codes -> FETCH on next edge, all enables 0 while in them.

Optional Feature:
MC_CTRL_MEMWAIT_EN
- Defined: adds input port mem_ready (1 bit). FETCH, MEMRD and MEMWR hold while mem_ready = 0.
  - ir_write, pc_write and mem_write are gated by mem_ready, so each asserts only in the completing cycle and exactly once per access.
  - A held state re-drives identical selects every cycle.
- Undefined: no port; memory is treated as single-cycle; behaviour as listed above.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum typedef (4-bit codes, FETCH = 0)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - alu_op, alu_src_b and pc_src encodings
- One natural sub-module: mc_ctrl_decode, the combinational state -> control-word decoder. The top keeps the state register, next-state logic and pc_en.

Test Plan:
- rst = 1 for 2 cycles, then release -> state_o = FETCH, ir_write = 1, pc_en = 1, alu_src_b = 1. In the following cycle state_o = DECODE.
- opcode = 0x23 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write = 1 with mem_to_reg = 1 only in MEMWB. Back to FETCH on cycle 6.
- opcode = 0x04 with zero = 1, then rerun with zero = 0 -> in BRANCH, pc_en = 1 with pc_src = 1 (zero = 1 run); pc_en = 0 (zero = 0 run). Both runs return to FETCH.
- opcode = 0x2B, rst asserted in MEMADR -> next state FETCH; mem_write never asserts.
- opcode = 0x3F -> illegal_op pulses exactly 1 cycle in DECODE; no reg_write or mem_write; next state FETCH.
- With MC_CTRL_MEMWAIT_EN, lw with mem_ready = 0 for 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB; in FETCH, ir_write is high for exactly 1 cycle.
